// File: rtl/mul_iter_if.sv
// Request/result bundle between the M-extension ALU (master) and the iterative multiplier (slave).
// Member names keep the multiplier-side _i/_o direction suffixes so both ends read the same.
interface mul_iter_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0]   op_a_i;
    logic [XLEN-1:0]   op_b_i;
    logic              req_i;
    logic              flush_i;
    logic              busy_o;
    logic              done_o;
    logic [2*XLEN-1:0] product_o;

    modport master (
        output op_a_i, op_b_i, req_i, flush_i,
        input  busy_o, done_o, product_o
    );

    modport slave (
        input  op_a_i, op_b_i, req_i, flush_i,
        output busy_o, done_o, product_o
    );
endinterface

// File: rtl/mul_iter.sv
// Iterative unsigned XLEN x XLEN multiplier, DIGIT_BITS multiplier bits per cycle, req/done handshake.
// Optional early completion on an exhausted multiplier: define MUL_ITER_EARLY_TERM_EN.
module mul_iter #(
    parameter int XLEN       = 64,
    parameter int DIGIT_BITS = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mul_iter_if.slave bus
);
    localparam int N     = XLEN / DIGIT_BITS;
    localparam int PW    = 2 * XLEN;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]   product_q;
    logic            busy_q;
    logic            done_q;

    logic [PW-1:0]   src_acc;
    logic [PW-1:0]   src_mcand;
    logic [XLEN-1:0] src_mplier;
    logic [CNT_W-1:0] src_cnt;

    logic [PW-1:0]   acc_d;
    logic [PW-1:0]   mcand_d;
    logic [XLEN-1:0] mplier_d;
    logic [CNT_W-1:0] cnt_d;
    logic            last_d;

    // Shift-add of one multiplier digit against the aligned multiplicand.
    function automatic logic [PW-1:0] digit_product(
        input logic [PW-1:0]         m,
        input logic [DIGIT_BITS-1:0] d
    );
        logic [PW-1:0] s;
        s = '0;
        for (int i = 0; i < DIGIT_BITS; i++) begin
            if (d[i]) begin
                s = s + (m << i);
            end
        end
        return s;
    endfunction

    // The acceptance edge already processes digit 0, so the result lands N cycles after req_i.
    always_comb begin
        src_acc    = acc_q;
        src_mcand  = mcand_q;
        src_mplier = mplier_q;
        src_cnt    = cnt_q;
        if (state_q == IDLE) begin
            src_acc    = '0;
            src_mcand  = {{XLEN{1'b0}}, bus.op_a_i};
            src_mplier = bus.op_b_i;
            src_cnt    = '0;
        end

        acc_d    = src_acc + digit_product(src_mcand, src_mplier[DIGIT_BITS-1:0]);
        mcand_d  = src_mcand << DIGIT_BITS;
        mplier_d = src_mplier >> DIGIT_BITS;
        cnt_d    = src_cnt + CNT_W'(1);

`ifdef MUL_ITER_EARLY_TERM_EN
        last_d = (src_cnt == CNT_W'(N - 1)) || (mplier_d == '0);
`else
        last_d = (src_cnt == CNT_W'(N - 1));
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_i && !bus.flush_i) begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_d;
                        if (last_d) begin
                            product_q <= acc_d;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (bus.flush_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_d;
                        if (last_d) begin
                            product_q <= acc_d;
                            done_q    <= 1'b1;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.product_o = product_q;
endmodule
